// File: rtl/jk_sync_counter.sv
// ---------------------------------------------------------------------------
// jk_sync_counter
//
// Synchronous WIDTH-bit up/down counter in which every bit is a JK stage.
// Counting drives each stage in toggle mode (J=K=T). Parallel load, and the
// modulo wrap when enabled, drive the stages in forced set/reset mode. The
// J/K vectors are exported so the per-bit stage inputs can be observed.
//
// Optional feature macro: JK_CNT_MOD_EN
//   undefined : pure binary wrap at 2^WIDTH (MODULUS is ignored)
//   defined   : counter runs modulo MODULUS
//
// Parameters:
//   WIDTH    counter width in bits (>= 2)
//   MODULUS  wrap modulus, used only with JK_CNT_MOD_EN (2..2^WIDTH)
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst       synchronous active-high reset (q=0, wrap=0)
//   en        count enable
//   up        direction: 1 = up, 0 = down
//   load      synchronous parallel load, overrides en
//   load_val  value written on load
//   q         registered counter value
//   jk_j      J applied to each bit stage this cycle (combinational)
//   jk_k      K applied to each bit stage this cycle (combinational)
//   tc        terminal count (combinational)
//   wrap      registered one-cycle pulse after an edge at which tc was 1
// ---------------------------------------------------------------------------
module jk_sync_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   output logic             tc,
   output logic             wrap
);

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 2) begin : g_bad_width
      $error("jk_sync_counter: WIDTH must be >= 2");
   end
   if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("jk_sync_counter: MODULUS must be in 2..2^WIDTH");
   end

   // Terminal value for up-counting.
`ifdef JK_CNT_MOD_EN
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
`else
   localparam logic [WIDTH-1:0] TOP = '1;
`endif

   logic [WIDTH-1:0] t_up;    // toggle vector for an increment
   logic [WIDTH-1:0] t_dn;    // toggle vector for a decrement
   logic [WIDTH-1:0] q_next;

   // Ripple-free toggle enables: bit i toggles when all lower bits are 1
   // (up) or all lower bits are 0 (down).
   // NOTE: every combinational output is given a default before any branch,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      t_up    = '0;
      t_dn    = '0;
      t_up[0] = 1'b1;
      t_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t_up[i] = t_up[i-1] & q[i-1];
         t_dn[i] = t_dn[i-1] & ~q[i-1];
      end
   end

   // J/K selection, priority load > en > hold. rst does not gate these; it
   // only overrides the register update.
   always_comb begin
      jk_j = '0;
      jk_k = '0;
      if (load) begin
         jk_j = load_val;
         jk_k = ~load_val;
      end else if (en) begin
         if (up) begin
`ifdef JK_CNT_MOD_EN
            // At or beyond the top (including out-of-range loaded values)
            // force every set bit clear so the next value is 0.
            if (q >= TOP) begin
               jk_j = '0;
               jk_k = q;
            end else begin
               jk_j = t_up;
               jk_k = t_up;
            end
`else
            jk_j = t_up;
            jk_k = t_up;
`endif
         end else begin
`ifdef JK_CNT_MOD_EN
            // Down from zero is forced to MODULUS-1 rather than all-ones.
            if (q == '0) begin
               jk_j = TOP;
               jk_k = ~TOP;
            end else begin
               jk_j = t_dn;
               jk_k = t_dn;
            end
`else
            jk_j = t_dn;
            jk_k = t_dn;
`endif
         end
      end
   end

   // JK characteristic equation per bit: Q+ = J&~Q | ~K&Q.
   // J=K=1 toggles cleanly, J=K=0 holds.
   assign q_next = (jk_j & ~q) | (~jk_k & q);

   assign tc = en & ~load & (up ? (q == TOP) : (q == '0));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= tc;
      end
   end

endmodule

// File: tb/tb_jk_sync_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_sync_counter
//
// Directed-vector bench for jk_sync_counter (WIDTH=4, MODULUS=10). A driver
// applies one input vector per cycle and pushes the expected outputs for
// that cycle into a scoreboard queue; a monitor samples the DUT on the
// falling edge, pops the matching entry and compares.
// ---------------------------------------------------------------------------
module tb_jk_sync_counter;

   typedef struct {
      logic [3:0] q;
      logic       tc;
      logic       wrap;
      logic [3:0] j;
      logic [3:0] k;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, en, up, load;
   logic [3:0] load_val;
   logic [3:0] q, jk_j, jk_k;
   logic       tc, wrap;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   bit   drv_done = 1'b0;

   jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .jk_j     (jk_j),
      .jk_k     (jk_k),
      .tc       (tc),
      .wrap     (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs; optionally queue the expected outputs.
   task automatic step(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input bit chk,
                       input logic [3:0] eq, input logic etc, input logic ew,
                       input logic [3:0] ej, input logic [3:0] ek, input string nm);
      exp_t x;
      rst = r; en = e; up = u; load = l; load_val = lv;
      if (chk) begin
         x.q = eq; x.tc = etc; x.wrap = ew; x.j = ej; x.k = ek; x.name = nm;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: one scoreboard entry per sampled cycle.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check({x.name, ".q"},    q,           x.q);
            check({x.name, ".tc"},   {3'b0, tc},  {3'b0, x.tc});
            check({x.name, ".wrap"}, {3'b0, wrap}, {3'b0, x.wrap});
            check({x.name, ".j"},    jk_j,        x.j);
            check({x.name, ".k"},    jk_k,        x.k);
         end
      end
   end

   // Driver
   initial begin
      logic [3:0] qv, m;
      // ---- reset with en/load active ----
      step(1, 1, 1, 1, 4'hA, 0, 4'h0, 0, 0, 4'h0, 4'h0, "");
      step(1, 1, 1, 1, 4'hA, 1, 4'h0, 0, 0, 4'hA, 4'h5, "rst_hold");
      step(0, 1, 1, 0, 4'h0, 1, 4'h0, 0, 0, 4'h1, 4'h1, "rst_rel");
      // ---- up count 1..F then 0 ----
      for (int n = 1; n <= 16; n++) begin
         qv = n[3:0];
         m  = qv ^ (qv + 4'd1);           // bits that flip on increment
         step(0, 1, 1, 0, 4'h0, 1, qv, (qv == 4'hF), (qv == 4'h0), m, m, "up");
      end
      // q=1 now
      // ---- down count ----
      step(0, 0, 1, 1, 4'h2, 1, 4'h1, 0, 0, 4'h2, 4'hD, "dn_load");
      step(0, 1, 0, 0, 4'h0, 1, 4'h2, 0, 0, 4'h3, 4'h3, "dn_2");
      step(0, 1, 0, 0, 4'h0, 1, 4'h1, 0, 0, 4'h1, 4'h1, "dn_1");
      step(0, 1, 0, 0, 4'h0, 1, 4'h0, 1, 0, 4'hF, 4'hF, "dn_0");
      step(0, 0, 0, 0, 4'h0, 1, 4'hF, 0, 1, 4'h0, 4'h0, "dn_F");
      // ---- load priority ----
      step(0, 0, 1, 1, 4'h5, 1, 4'hF, 0, 0, 4'h5, 4'hA, "ld_5");
      step(0, 1, 1, 1, 4'hC, 1, 4'h5, 0, 0, 4'hC, 4'h3, "ld_over_en");
      step(0, 0, 1, 0, 4'h0, 1, 4'hC, 0, 0, 4'h0, 4'h0, "hold_1");
      step(0, 0, 1, 0, 4'h0, 1, 4'hC, 0, 0, 4'h0, 4'h0, "hold_2");
      // load wins at the terminal value: tc suppressed, no wrap afterwards
      step(0, 0, 1, 1, 4'hF, 1, 4'hC, 0, 0, 4'hF, 4'h0, "ld_F");
      step(0, 1, 1, 1, 4'h3, 1, 4'hF, 0, 0, 4'h3, 4'hC, "ld_at_top");
      step(0, 0, 1, 0, 4'h0, 1, 4'h3, 0, 0, 4'h0, 4'h0, "no_wrap");
      // ---- direction change, no dead cycle ----
      step(0, 1, 1, 0, 4'h0, 1, 4'h3, 0, 0, 4'h7, 4'h7, "dir_up");
      step(0, 1, 0, 0, 4'h0, 1, 4'h4, 0, 0, 4'h7, 4'h7, "dir_dn");
      step(0, 0, 0, 0, 4'h0, 1, 4'h3, 0, 0, 4'h0, 4'h0, "dir_hold");
      // ---- mid-operation reset ----
      step(0, 0, 1, 1, 4'h5, 1, 4'h3, 0, 0, 4'h5, 4'hA, "mr_ld5");
      step(0, 1, 1, 0, 4'h0, 1, 4'h5, 0, 0, 4'h3, 4'h3, "mr_up");
      step(1, 1, 1, 1, 4'hA, 1, 4'h6, 0, 0, 4'hA, 4'h5, "mr_rst");
      step(0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 4'h0, 4'h0, "mr_after");
      // reset while tc is high must also clear the wrap pulse
      step(0, 0, 1, 1, 4'hF, 1, 4'h0, 0, 0, 4'hF, 4'h0, "rt_ldF");
      step(1, 1, 1, 0, 4'h0, 1, 4'hF, 1, 0, 4'hF, 4'hF, "rt_rst");
      step(0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 4'h0, 4'h0, "rt_after");
`ifdef JK_CNT_MOD_EN
      // ---- modulo 10 ----
      step(0, 0, 1, 1, 4'h8, 1, 4'h0, 0, 0, 4'h8, 4'h7, "m_ld8");
      step(0, 1, 1, 0, 4'h0, 1, 4'h8, 0, 0, 4'h1, 4'h1, "m_8");
      step(0, 1, 1, 0, 4'h0, 1, 4'h9, 1, 0, 4'h0, 4'h9, "m_9");
      step(0, 1, 0, 0, 4'h0, 1, 4'h0, 1, 1, 4'h9, 4'h6, "m_0dn");
      step(0, 0, 0, 0, 4'h0, 1, 4'h9, 0, 1, 4'h0, 4'h0, "m_to9");
      step(0, 0, 1, 1, 4'hD, 1, 4'h9, 0, 0, 4'hD, 4'h2, "m_ldD");
      step(0, 1, 1, 0, 4'h0, 1, 4'hD, 0, 0, 4'h0, 4'hD, "m_D");
      step(0, 0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 4'h0, 4'h0, "m_D0");
`endif
      drv_done = 1'b1;
   end

   // Completion with a bounded drain of the scoreboard.
   initial begin
      int budget;
      budget = 2000;
      while (!drv_done && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      repeat (3) @(posedge clk);
      checks++;
      if (!drv_done || sb.size() != 0) begin
         failures++;
         $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0",
                  drv_done, sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
